// File: rtl/mtm_alu_deserializer.sv
// mtm_Alu serial receiver: frames sin into 8 data bytes + command byte.
// Ports: clk, reset_n, sin in; a, b, ctl, pkt_valid, err_data, err_frame out.
module mtm_alu_deserializer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [7:0]  ctl,
  output logic        pkt_valid,
  output logic        err_data,
  output logic        err_frame
);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    RX
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic        flag_q, flag_d;
  logic [7:0]  byte_q, byte_d;
  // data byte count; 9 marks an over-long packet
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] asm_q, asm_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [7:0]  ctl_q, ctl_d;
  logic        pv_q, pv_d;
  logic        ed_q, ed_d;
  logic        ef_q, ef_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARM;
      bit_q   <= '0;
      flag_q  <= 1'b0;
      byte_q  <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      pv_q    <= 1'b0;
      ed_q    <= 1'b0;
      ef_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      flag_q  <= flag_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      pv_q    <= pv_d;
      ed_q    <= ed_d;
      ef_q    <= ef_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    flag_d  = flag_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    a_d     = a_q;
    b_d     = b_q;
    ctl_d   = ctl_q;
    pv_d    = 1'b0;
    ed_d    = 1'b0;
    ef_d    = 1'b0;
    unique case (state_q)
      ARM: begin
        // ignore the low line level seen right after reset
        if (sin) state_d = IDLE;
      end
      IDLE: begin
        if (!sin) begin
          state_d = RX;
          bit_d   = '0;
        end
      end
      RX: begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd0) begin
          flag_d = sin;
        end else if (bit_q <= 4'd8) begin
          byte_d = {byte_q[6:0], sin};
        end else begin
          bit_d = '0;
          if (!sin) begin
            ef_d    = 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
            state_d = ARM;
          end else begin
            state_d = IDLE;
            if (!flag_q) begin
              if (cnt_q < 4'd8) begin
                asm_d = {asm_q[55:0], byte_q};
                cnt_d = cnt_q + 4'd1;
              end else begin
                cnt_d = 4'd9;
              end
            end else begin
              cnt_d = '0;
              if (cnt_q == 4'd8) begin
                b_d   = asm_q[63:32];
                a_d   = asm_q[31:0];
                ctl_d = byte_q;
                pv_d  = 1'b1;
              end else begin
                ed_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign ctl       = ctl_q;
  assign pkt_valid = pv_q;
  assign err_data  = ed_q;
  assign err_frame = ef_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench for mtm_alu_deserializer.
// Frame-level reference model; directed steps plus random packets.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sin = 1'b0;
  logic [31:0] a, b;
  logic [7:0]  ctl;
  logic        pkt_valid, err_data, err_frame;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sin       (sin),
    .a         (a),
    .b         (b),
    .ctl       (ctl),
    .pkt_valid (pkt_valid),
    .err_data  (err_data),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pv_cnt = 0, ed_cnt = 0, ef_cnt = 0;
  int last_pv = -1;
  int start_cyc = 0;

  // reference model state
  logic [7:0]  mq[$];
  bit          movf = 1'b0;
  logic [31:0] ea = '0, eb = '0;
  logic [7:0]  ectl = '0;
  int          epv = 0, eed = 0, eef = 0;
  logic [7:0]  tx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pkt_valid) begin
      pv_cnt++;
      last_pv = cyc;
    end
    if (err_data) ed_cnt++;
    if (err_frame) ef_cnt++;
    if (pkt_valid || err_data || err_frame)
      chk("onehot", 64'(int'(pkt_valid) + int'(err_data) + int'(err_frame)), 64'd1);
  end

  function automatic void mdl(input bit flag, input logic [7:0] d,
                              input bit stop);
    if (!stop) begin
      eef++;
      mq.delete();
      movf = 1'b0;
    end else if (!flag) begin
      if (mq.size() < 8) mq.push_back(d);
      else movf = 1'b1;
    end else begin
      if (mq.size() == 8 && !movf) begin
        eb   = {mq[0], mq[1], mq[2], mq[3]};
        ea   = {mq[4], mq[5], mq[6], mq[7]};
        ectl = d;
        epv++;
      end else begin
        eed++;
      end
      mq.delete();
      movf = 1'b0;
    end
  endfunction

  task automatic send_frame(input bit flag, input logic [7:0] d,
                            input bit stop, input int nbits);
    logic [10:0] f;
    f = {1'b0, flag, d, stop};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sin = f[10-i];
      if (i == 0) start_cyc = cyc + 1;
    end
    if (nbits == 11) mdl(flag, d, stop);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b1;
    end
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input int gap);
    foreach (tx_q[i]) begin
      send_frame(1'b0, tx_q[i], 1'b1, 11);
      idle(gap);
    end
    send_frame(1'b1, cmd, 1'b1, 11);
  endtask

  task automatic rand_bytes(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic check_all(input string tag);
    idle(3);
    chk({tag, ".pv"}, 64'(pv_cnt), 64'(epv));
    chk({tag, ".ed"}, 64'(ed_cnt), 64'(eed));
    chk({tag, ".ef"}, 64'(ef_cnt), 64'(eef));
    chk({tag, ".a"}, 64'(a), 64'(ea));
    chk({tag, ".b"}, 64'(b), 64'(eb));
    chk({tag, ".ctl"}, 64'(ctl), 64'(ectl));
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 1'b0;
    ea = '0;
    eb = '0;
    ectl = '0;
  endtask

  initial begin
    int cmd_start;
    int n, gap;
    repeat (3) @(negedge clk);
    chk("rst.a", 64'(a), 64'd0);
    chk("rst.b", 64'(b), 64'd0);
    chk("rst.ctl", 64'(ctl), 64'd0);
    chk("rst.pulses", 64'({pkt_valid, err_data, err_frame}), 64'd0);

    // release with the line still low: must not be seen as a start bit
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    idle(2);
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(8'h25, 2);
    check_all("basic");
    chk("basic.bval", 64'(b), 64'h11223344);
    chk("basic.aval", 64'(a), 64'h55667788);

    // zero idle gaps, and pulse timing
    send_pkt(8'h25, 0);
    cmd_start = start_cyc;
    check_all("b2b");
    chk("b2b.lat", 64'(last_pv - cmd_start), 64'd10);

    // short packet
    rand_bytes(7);
    send_pkt(8'h10, 1);
    check_all("short");
    rand_bytes(8);
    send_pkt(8'($urandom), 1);
    check_all("after_short");

    // long packet
    rand_bytes(10);
    send_pkt(8'h3c, 0);
    check_all("long");

    // stop bit error mid-packet, then a low line that must be ignored
    rand_bytes(3);
    foreach (tx_q[i]) send_frame(1'b0, tx_q[i], 1'b1, 11);
    send_frame(1'b0, 8'ha5, 1'b0, 11);
    repeat (14) begin
      @(negedge clk);
      sin = 1'b0;
    end
    chk("ferr.ef", 64'(ef_cnt), 64'(eef));
    chk("ferr.pv", 64'(pv_cnt), 64'(epv));
    idle(2);
    rand_bytes(8);
    send_pkt(8'($urandom), 0);
    check_all("after_ferr");

    // async reset at d3 of the 4th data byte
    rand_bytes(3);
    foreach (tx_q[i]) send_frame(1'b0, tx_q[i], 1'b1, 11);
    send_frame(1'b0, 8'hc3, 1'b1, 7);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst.a", 64'(a), 64'd0);
    chk("arst.b", 64'(b), 64'd0);
    chk("arst.ctl", 64'(ctl), 64'd0);
    @(negedge clk);
    sin = 1'b1;
    reset_n = 1'b1;
    idle(2);
    rand_bytes(8);
    send_pkt(8'($urandom), 1);
    check_all("after_arst");

    // random packets: varying length, gaps, occasional stop errors
    for (int p = 0; p < 25; p++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : 8;
      gap = int'($urandom_range(0, 3));
      rand_bytes(n);
      foreach (tx_q[i]) begin
        if ($urandom_range(0, 40) == 0) begin
          send_frame(1'b0, tx_q[i], 1'b0, 11);
          idle(gap + 1);
        end else begin
          send_frame(1'b0, tx_q[i], 1'b1, 11);
          idle(gap);
        end
      end
      send_frame(1'b1, 8'($urandom), 1'b1, 11);
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
